// File: rtl/shared_ram_arbiter.sv
// shared_ram_arbiter
//   Arbitrates one single-port synchronous RAM (one-cycle read latency) between the
//   M68K shared-RAM window and the Z80 0x8000-0x87FF region. Each access runs
//   IDLE -> ACC -> RD -> IDLE. The 68K gets a registered DTACK. The Z80 gets a WAIT
//   that asserts combinationally in the same cycle its request arrives.
//   Collisions resolve round-robin, or always to the 68K when FIXED_PRIO=1.
//   Optional feature macro: SHARED_RAM_STATS_EN enables the saturating collision
//   counter on conflict_cnt. When it is undefined, conflict_cnt is tied to zero.
module shared_ram_arbiter #(
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 8,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              m68k_req,
    input  logic              m68k_rw,
    input  logic [ADDR_W-1:0] m68k_addr,
    input  logic [DATA_W-1:0] m68k_din,
    output logic [DATA_W-1:0] m68k_dout,
    output logic              m68k_dtack_n,
    input  logic              z80_req,
    input  logic              z80_wr,
    input  logic [ADDR_W-1:0] z80_addr,
    input  logic [DATA_W-1:0] z80_din,
    output logic [DATA_W-1:0] z80_dout,
    output logic              z80_wait_n,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_dout,
    output logic [15:0]       conflict_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_RD   = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_owner_z80;   // 1: Z80 holds (or last held) the RAM
    logic              r_wr;          // the access in flight is a write
    logic              r_m_done;
    logic              r_z_done;
    logic [DATA_W-1:0] r_m_dout;
    logic [DATA_W-1:0] r_z_dout;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_din;
    logic              r_ram_we;

    logic              w_m_elig;
    logic              w_z_elig;
    logic              w_collide;
    logic              w_grant_z80;

    // A master can be granted only once per request; done blocks a re-grant until req drops.
    assign w_m_elig  = m68k_req & ~r_m_done;
    assign w_z_elig  = z80_req & ~r_z_done;
    assign w_collide = w_m_elig & w_z_elig;

    // Pick the winner for this IDLE cycle. On a collision, round-robin hands the RAM to
    // whichever master did not own it last.
    always_comb begin
        w_grant_z80 = w_z_elig;
        if (w_collide) begin
            w_grant_z80 = (FIXED_PRIO != 0) ? 1'b0 : ~r_owner_z80;
        end
    end

    // Access sequencer. RAM controls are registered on the grant edge so that the ACC
    // cycle presents them. Read data is captured on the RD exit edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_owner_z80 <= 1'b1;
            r_wr        <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_din   <= '0;
            r_ram_we    <= 1'b0;
            r_m_dout    <= '0;
            r_z_dout    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_ram_we <= 1'b0;
                    if (w_m_elig | w_z_elig) begin
                        r_state     <= ST_ACC;
                        r_owner_z80 <= w_grant_z80;
                        r_wr        <= w_grant_z80 ? z80_wr : ~m68k_rw;
                        r_ram_we    <= w_grant_z80 ? z80_wr : ~m68k_rw;
                        r_ram_addr  <= w_grant_z80 ? z80_addr : m68k_addr;
                        r_ram_din   <= w_grant_z80 ? z80_din : m68k_din;
                    end
                end
                ST_ACC: begin
                    r_ram_we <= 1'b0;
                    r_state  <= ST_RD;
                end
                ST_RD: begin
                    r_state <= ST_IDLE;
                    if (!r_wr) begin
                        if (r_owner_z80) begin
                            r_z_dout <= ram_dout;
                        end else begin
                            r_m_dout <= ram_dout;
                        end
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_ram_we <= 1'b0;
                end
            endcase
        end
    end

    // Done flags: set when the owner's access leaves RD while its request is still high,
    // and cleared on the first cycle the request is seen low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_m_done <= 1'b0;
            r_z_done <= 1'b0;
        end else begin
            if ((r_state == ST_RD) && !r_owner_z80 && m68k_req) begin
                r_m_done <= 1'b1;
            end else if (!m68k_req) begin
                r_m_done <= 1'b0;
            end
            if ((r_state == ST_RD) && r_owner_z80 && z80_req) begin
                r_z_done <= 1'b1;
            end else if (!z80_req) begin
                r_z_done <= 1'b0;
            end
        end
    end

`ifdef SHARED_RAM_STATS_EN
    logic [15:0] r_conflict_cnt;

    // Count IDLE cycles in which both masters are eligible. The count saturates at all-ones.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_conflict_cnt <= 16'h0000;
        end else if ((r_state == ST_IDLE) && w_collide && (r_conflict_cnt != 16'hFFFF)) begin
            r_conflict_cnt <= r_conflict_cnt + 16'd1;
        end
    end

    assign conflict_cnt = r_conflict_cnt;
`else
    assign conflict_cnt = 16'h0000;
`endif

    assign m68k_dout    = r_m_dout;
    assign m68k_dtack_n = ~r_m_done;
    assign z80_dout     = r_z_dout;
    assign z80_wait_n   = ~(z80_req & ~r_z_done);
    assign ram_addr     = r_ram_addr;
    assign ram_din      = r_ram_din;
    assign ram_we       = r_ram_we;

endmodule

// File: tb/tb_shared_ram_arbiter.sv
// Testbench for shared_ram_arbiter: a round-robin instance plus a FIXED_PRIO=1 instance,
// each wired to a behavioural synchronous RAM. A reference memory and an expected-owner
// model predict read data, acknowledge latency and grant order.
module tb_shared_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    always #5 clk = ~clk;

    // Round-robin instance
    logic        m68k_req, m68k_rw, m68k_dtack_n;
    logic [10:0] m68k_addr;
    logic [7:0]  m68k_din, m68k_dout;
    logic        z80_req, z80_wr, z80_wait_n;
    logic [10:0] z80_addr;
    logic [7:0]  z80_din, z80_dout;
    logic [10:0] ram_addr;
    logic [7:0]  ram_din, ram_dout;
    logic        ram_we;
    logic [15:0] conflict_cnt;

    // Fixed-priority instance
    logic        b_m_req, b_m_rw, b_m_dtack_n;
    logic [10:0] b_m_addr;
    logic [7:0]  b_m_din, b_m_dout;
    logic        b_z_req, b_z_wr, b_z_wait_n;
    logic [10:0] b_z_addr;
    logic [7:0]  b_z_din, b_z_dout;
    logic [10:0] b_ram_addr;
    logic [7:0]  b_ram_din, b_ram_dout;
    logic        b_ram_we;
    logic [15:0] b_cnt;

    shared_ram_arbiter #(.ADDR_W(11), .DATA_W(8), .FIXED_PRIO(0)) dut (
        .clk(clk), .reset_n(reset_n),
        .m68k_req(m68k_req), .m68k_rw(m68k_rw), .m68k_addr(m68k_addr), .m68k_din(m68k_din),
        .m68k_dout(m68k_dout), .m68k_dtack_n(m68k_dtack_n),
        .z80_req(z80_req), .z80_wr(z80_wr), .z80_addr(z80_addr), .z80_din(z80_din),
        .z80_dout(z80_dout), .z80_wait_n(z80_wait_n),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
        .conflict_cnt(conflict_cnt)
    );

    shared_ram_arbiter #(.ADDR_W(11), .DATA_W(8), .FIXED_PRIO(1)) dut_fp (
        .clk(clk), .reset_n(reset_n),
        .m68k_req(b_m_req), .m68k_rw(b_m_rw), .m68k_addr(b_m_addr), .m68k_din(b_m_din),
        .m68k_dout(b_m_dout), .m68k_dtack_n(b_m_dtack_n),
        .z80_req(b_z_req), .z80_wr(b_z_wr), .z80_addr(b_z_addr), .z80_din(b_z_din),
        .z80_dout(b_z_dout), .z80_wait_n(b_z_wait_n),
        .ram_addr(b_ram_addr), .ram_din(b_ram_din), .ram_we(b_ram_we), .ram_dout(b_ram_dout),
        .conflict_cnt(b_cnt)
    );

    // Synchronous single-port RAMs with one-cycle read latency
    logic [7:0] mem_a [0:2047];
    logic [7:0] mem_b [0:2047];
    always @(posedge clk) begin
        if (ram_we) mem_a[ram_addr] <= ram_din;
        ram_dout <= mem_a[ram_addr];
    end
    always @(posedge clk) begin
        if (b_ram_we) mem_b[b_ram_addr] <= b_ram_din;
        b_ram_dout <= mem_b[b_ram_addr];
    end

    // Reference model state
    logic [7:0]  ref_mem [0:2047];
    logic [10:0] pool [0:7];
    bit          exp_last_z;     // master expected to have owned the RAM last (1 = Z80)
    int          exp_cnt;
    int          exp_b_cnt;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic do_reset();
        reset_n  = 1'b0;
        m68k_req = 1'b0;
        z80_req  = 1'b0;
        b_m_req  = 1'b0;
        b_z_req  = 1'b0;
        repeat (2) @(negedge clk);
        reset_n    = 1'b1;
        exp_last_z = 1'b1;
        exp_cnt    = 0;
        exp_b_cnt  = 0;
        @(negedge clk);
    endtask

    // One isolated access by one master, including the release handshake afterwards.
    task automatic access(input bit is_z, input bit wr, input logic [10:0] addr, input logic [7:0] data);
        int lat;
        bit got;
        logic [7:0] old_dout;
        logic [7:0] act;
        old_dout = is_z ? z80_dout : m68k_dout;
        if (is_z) begin
            z80_wr = wr; z80_addr = addr; z80_din = data; z80_req = 1'b1;
        end else begin
            m68k_rw = ~wr; m68k_addr = addr; m68k_din = data; m68k_req = 1'b1;
        end
        #1;
        if (is_z) begin
            n_vec++;
            if (z80_wait_n !== 1'b0) begin
                n_err++; $display("FAIL wait_on_req: wait_n=%b required 0", z80_wait_n);
            end
        end
        lat = 0;
        got = 1'b0;
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                n_vec++;
                if (ram_we !== wr || ram_addr !== addr || (wr && ram_din !== data)) begin
                    n_err++;
                    $display("FAIL acc_cycle: we=%b addr=%h din=%h required we=%b addr=%h din=%h",
                             ram_we, ram_addr, ram_din, wr, addr, data);
                end
            end
            if (lat == 2) begin
                n_vec++;
                if (ram_we !== 1'b0) begin
                    n_err++; $display("FAIL we_pulse: ram_we=%b in RD required 0", ram_we);
                end
            end
            got = is_z ? (z80_wait_n === 1'b1) : (m68k_dtack_n === 1'b0);
        end
        n_vec++;
        if (!got || lat != 3) begin
            n_err++; $display("FAIL ack_latency: master=%0d latency=%0d got=%b required 3", is_z, lat, got);
        end
        act = is_z ? z80_dout : m68k_dout;
        n_vec++;
        if (wr) begin
            ref_mem[addr] = data;
            if (act !== old_dout) begin
                n_err++; $display("FAIL write_dout: master=%0d dout=%h required unchanged %h", is_z, act, old_dout);
            end
        end else if (act !== ref_mem[addr]) begin
            n_err++; $display("FAIL read_data: master=%0d addr=%h dout=%h required %h", is_z, addr, act, ref_mem[addr]);
        end
        exp_last_z = is_z;
        if (is_z) z80_req = 1'b0; else m68k_req = 1'b0;
        @(negedge clk);
        n_vec++;
        if (m68k_dtack_n !== 1'b1 || z80_wait_n !== 1'b1 || ram_we !== 1'b0) begin
            n_err++; $display("FAIL release: dtack_n=%b wait_n=%b we=%b required 1 1 0", m68k_dtack_n, z80_wait_n, ram_we);
        end
    endtask

    // Both masters request on the same edge. Addresses must differ.
    task automatic collide(input bit m_wr, input logic [10:0] m_a, input logic [7:0] m_d,
                           input bit z_wr, input logic [10:0] z_a, input logic [7:0] z_d);
        int m_lat, z_lat;
        bit z_first;
        z_first = !exp_last_z;
        m68k_rw = ~m_wr; m68k_addr = m_a; m68k_din = m_d;
        z80_wr = z_wr; z80_addr = z_a; z80_din = z_d;
        m68k_req = 1'b1; z80_req = 1'b1;
        m_lat = 0; z_lat = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (m_lat == 0 && m68k_dtack_n === 1'b0) m_lat = c;
            if (z_lat == 0 && z80_wait_n === 1'b1) z_lat = c;
        end
        n_vec++;
        if (m_lat != (z_first ? 6 : 3) || z_lat != (z_first ? 3 : 6)) begin
            n_err++;
            $display("FAIL collision_order: m68k_lat=%0d z80_lat=%0d required %0d %0d",
                     m_lat, z_lat, z_first ? 6 : 3, z_first ? 3 : 6);
        end
        if (m_wr) ref_mem[m_a] = m_d;
        if (z_wr) ref_mem[z_a] = z_d;
        if (!m_wr) begin
            n_vec++;
            if (m68k_dout !== ref_mem[m_a]) begin
                n_err++; $display("FAIL coll_m_read: dout=%h required %h", m68k_dout, ref_mem[m_a]);
            end
        end
        if (!z_wr) begin
            n_vec++;
            if (z80_dout !== ref_mem[z_a]) begin
                n_err++; $display("FAIL coll_z_read: dout=%h required %h", z80_dout, ref_mem[z_a]);
            end
        end
        exp_last_z = !z_first;
`ifdef SHARED_RAM_STATS_EN
        exp_cnt++;
`endif
        m68k_req = 1'b0; z80_req = 1'b0;
        @(negedge clk);
        n_vec++;
        if (conflict_cnt !== 16'(exp_cnt)) begin
            n_err++; $display("FAIL conflict_cnt: cnt=%0d required %0d", conflict_cnt, exp_cnt);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #1;
        n_vec++;
        if (m68k_dout !== 8'h00 || z80_dout !== 8'h00 || m68k_dtack_n !== 1'b1 || z80_wait_n !== 1'b1 ||
            ram_we !== 1'b0 || ram_addr !== 11'h000 || ram_din !== 8'h00 || conflict_cnt !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_values: mdout=%h zdout=%h dtack_n=%b wait_n=%b we=%b addr=%h din=%h cnt=%h required 00 00 1 1 0 000 00 0000",
                     m68k_dout, z80_dout, m68k_dtack_n, z80_wait_n, ram_we, ram_addr, ram_din, conflict_cnt);
        end
        do_reset();
        n_vec++;
        if (m68k_dtack_n !== 1'b1 || z80_wait_n !== 1'b1 || ram_we !== 1'b0 || b_m_dtack_n !== 1'b1 || b_z_wait_n !== 1'b1) begin
            n_err++; $display("FAIL idle_after_reset: dtack_n=%b wait_n=%b we=%b required 1 1 0", m68k_dtack_n, z80_wait_n, ram_we);
        end
    endtask

    task automatic test_basic();
        access(1'b1, 1'b1, 11'h010, 8'h5A);
        access(1'b0, 1'b0, 11'h010, 8'h00);
        access(1'b1, 1'b1, 11'h7FF, 8'hA5);
        access(1'b1, 1'b0, 11'h7FF, 8'h00);
        access(1'b0, 1'b1, 11'h123, 8'h3C);
        access(1'b1, 1'b0, 11'h123, 8'h00);
    endtask

    task automatic test_collision_rr();
        do_reset();
        collide(1'b1, 11'h2AA, 8'h11, 1'b1, 11'h155, 8'h22);
        collide(1'b0, 11'h155, 8'h00, 1'b0, 11'h2AA, 8'h00);
    endtask

    task automatic test_hold_ack();
        int lat;
        m68k_rw = 1'b1; m68k_addr = 11'h010; m68k_req = 1'b1;
        lat = 0;
        while (m68k_dtack_n !== 1'b0 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        n_vec++;
        if (lat != 3) begin
            n_err++; $display("FAIL hold_first_ack: latency=%0d required 3", lat);
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_vec++;
            if (m68k_dtack_n !== 1'b0 || ram_we !== 1'b0 || ram_addr !== 11'h010) begin
                n_err++; $display("FAIL hold_no_reaccess: dtack_n=%b we=%b addr=%h required 0 0 010", m68k_dtack_n, ram_we, ram_addr);
            end
        end
        exp_last_z = 1'b0;
        m68k_req = 1'b0;
        @(negedge clk);
        n_vec++;
        if (m68k_dtack_n !== 1'b1) begin
            n_err++; $display("FAIL hold_release: dtack_n=%b required 1", m68k_dtack_n);
        end
        access(1'b0, 1'b0, 11'h7FF, 8'h00);
    endtask

    task automatic test_drop_mid();
        z80_wr = 1'b1; z80_addr = 11'h400; z80_din = 8'hC7; z80_req = 1'b1;
        @(negedge clk);
        z80_req = 1'b0;
        repeat (3) @(negedge clk);
        ref_mem[11'h400] = 8'hC7;
        exp_last_z = 1'b1;
        n_vec++;
        if (z80_wait_n !== 1'b1 || ram_we !== 1'b0) begin
            n_err++; $display("FAIL drop_write_idle: wait_n=%b we=%b required 1 0", z80_wait_n, ram_we);
        end
        access(1'b0, 1'b0, 11'h400, 8'h00);
        access(1'b1, 1'b0, 11'h7FF, 8'h00);
        z80_wr = 1'b0; z80_addr = 11'h123; z80_req = 1'b1;
        @(negedge clk);
        z80_req = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (z80_dout !== ref_mem[11'h123]) begin
            n_err++; $display("FAIL drop_read_dout: dout=%h required %h", z80_dout, ref_mem[11'h123]);
        end
    endtask

    task automatic test_reset_mid_access();
        int lat;
        z80_wr = 1'b1; z80_addr = 11'h5C3; z80_din = 8'h96; z80_req = 1'b1;
        @(negedge clk);
        n_vec++;
        if (ram_we !== 1'b1 || ram_addr !== 11'h5C3) begin
            n_err++; $display("FAIL rst_acc_seen: we=%b addr=%h required 1 5c3", ram_we, ram_addr);
        end
        reset_n = 1'b0;
        #1;
        n_vec++;
        if (ram_we !== 1'b0 || ram_addr !== 11'h000 || ram_din !== 8'h00 || m68k_dout !== 8'h00 ||
            z80_dout !== 8'h00 || m68k_dtack_n !== 1'b1 || conflict_cnt !== 16'h0000) begin
            n_err++;
            $display("FAIL rst_async: we=%b addr=%h din=%h mdout=%h zdout=%h dtack_n=%b cnt=%h required 0 000 00 00 00 1 0000",
                     ram_we, ram_addr, ram_din, m68k_dout, z80_dout, m68k_dtack_n, conflict_cnt);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        exp_cnt = 0;
        exp_b_cnt = 0;
        lat = 0;
        while (z80_wait_n !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        n_vec++;
        if (lat != 3) begin
            n_err++; $display("FAIL rst_reserve: latency=%0d required 3", lat);
        end
        ref_mem[11'h5C3] = 8'h96;
        exp_last_z = 1'b1;
        z80_req = 1'b0;
        @(negedge clk);
        access(1'b0, 1'b0, 11'h5C3, 8'h00);
    endtask

    task automatic test_random();
        int i, j;
        for (int k = 0; k < 8; k++) access(k[0], 1'b1, pool[k], 8'($urandom_range(0, 255)));
        for (int n = 0; n < 40; n++) begin
            i = $urandom_range(0, 7);
            if ($urandom_range(0, 3) == 0) begin
                j = (i + 1 + $urandom_range(0, 6)) % 8;
                collide(1'($urandom_range(0, 1)), pool[i], 8'($urandom_range(0, 255)),
                        1'($urandom_range(0, 1)), pool[j], 8'($urandom_range(0, 255)));
            end else begin
                access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pool[i], 8'($urandom_range(0, 255)));
            end
        end
    endtask

    // A lone 68K access first makes the 68K the last owner, so round-robin would favour the Z80.
    task automatic test_fixed_prio();
        int m_lat, z_lat;
        for (int r = 0; r < 3; r++) begin
            b_m_rw = 1'b0; b_m_addr = 11'(r); b_m_din = 8'(r + 1); b_m_req = 1'b1;
            repeat (3) @(negedge clk);
            n_vec++;
            if (b_m_dtack_n !== 1'b0) begin
                n_err++; $display("FAIL fp_single: dtack_n=%b required 0", b_m_dtack_n);
            end
            b_m_req = 1'b0;
            @(negedge clk);
            b_m_addr = 11'h100; b_m_din = 8'h77; b_z_wr = 1'b1; b_z_addr = 11'h200; b_z_din = 8'h88;
            b_m_req = 1'b1; b_z_req = 1'b1;
            m_lat = 0; z_lat = 0;
            for (int c = 1; c <= 12; c++) begin
                @(negedge clk);
                if (m_lat == 0 && b_m_dtack_n === 1'b0) m_lat = c;
                if (z_lat == 0 && b_z_wait_n === 1'b1) z_lat = c;
            end
            n_vec++;
            if (m_lat != 3 || z_lat != 6) begin
                n_err++; $display("FAIL fp_order: m68k_lat=%0d z80_lat=%0d required 3 6", m_lat, z_lat);
            end
`ifdef SHARED_RAM_STATS_EN
            exp_b_cnt++;
`endif
            b_m_req = 1'b0; b_z_req = 1'b0;
            @(negedge clk);
        end
        n_vec++;
        if (b_cnt !== 16'(exp_b_cnt) || b_m_dout !== 8'h00 || b_z_dout !== 8'h00) begin
            n_err++; $display("FAIL fp_final: cnt=%0d mdout=%h zdout=%h required %0d 00 00", b_cnt, b_m_dout, b_z_dout, exp_b_cnt);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        m68k_req = 1'b0; m68k_rw = 1'b1; m68k_addr = '0; m68k_din = '0;
        z80_req = 1'b0; z80_wr = 1'b0; z80_addr = '0; z80_din = '0;
        b_m_req = 1'b0; b_m_rw = 1'b1; b_m_addr = '0; b_m_din = '0;
        b_z_req = 1'b0; b_z_wr = 1'b0; b_z_addr = '0; b_z_din = '0;
        reset_n = 1'b1;
        pool[0] = 11'h000; pool[1] = 11'h010; pool[2] = 11'h2AA; pool[3] = 11'h155;
        pool[4] = 11'h400; pool[5] = 11'h7FF; pool[6] = 11'h123; pool[7] = 11'h5C3;
        @(negedge clk);
        test_reset();
        test_basic();
        test_collision_rr();
        test_hold_ack();
        test_drop_mid();
        test_reset_mid_access();
        test_fixed_prio();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
